// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a shared single-port memory
// Alternates grants under contention and aborts a hung access after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ireq,
  input  logic [WORD-1:0] iaddr,
  output logic [WORD-1:0] irdata,
  output logic            ivalid,
  input  logic            dreq,
  input  logic            dwe,
  input  logic [WORD-1:0] daddr,
  input  logic [WORD-1:0] dwdata,
  output logic [WORD-1:0] drdata,
  output logic            dvalid,
  output logic            mreq,
  output logic            mwe,
  output logic [WORD-1:0] maddr,
  output logic [WORD-1:0] mwdata,
  input  logic            mready,
  input  logic [WORD-1:0] mrdata,
  output logic            stallF,
  output logic            stallM,
  output logic            err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t          state, next_state;
  logic            last_d;
  logic [CW-1:0]   cnt;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic            we_q;

  logic i_elig, d_elig, busy, expired, done, grant_i, grant_d;

  // A requester whose valid is high this cycle is finishing, not asking again.
  assign i_elig  = ireq & ~ivalid;
  assign d_elig  = dreq & ~dvalid;
  assign busy    = (state != IDLE);
  assign expired = busy & ~mready & (cnt == LIMIT);
  assign done    = busy & (mready | expired);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && (!i_elig || !last_d)) begin
          grant_d    = 1'b1;
          next_state = DBUSY;
        end else if (i_elig) begin
          grant_i    = 1'b1;
          next_state = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d  <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      irdata  <= '0;
      drdata  <= '0;
      ivalid  <= 1'b0;
      dvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      if (grant_i) begin
        last_d  <= 1'b0;
        addr_q  <= iaddr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        cnt     <= '0;
      end else if (grant_d) begin
        last_d  <= 1'b1;
        addr_q  <= daddr;
        wdata_q <= dwdata;
        we_q    <= dwe;
        cnt     <= '0;
      end else if (busy && !done) begin
        cnt <= cnt + 1'b1;
      end
      if (expired) err <= 1'b1;
      if (done && state == IBUSY) begin
        ivalid <= 1'b1;
        irdata <= mready ? mrdata : '0;
      end
      // A write leaves drdata alone; an aborted access returns zero.
      if (done && state == DBUSY) begin
        dvalid <= 1'b1;
        if (!mready)    drdata <= '0;
        else if (!we_q) drdata <= mrdata;
      end
    end
  end

  assign mreq   = busy;
  assign mwe    = busy & we_q;
  assign maddr  = addr_q;
  assign mwdata = wdata_q;
  assign stallF = ireq & ~ivalid;
  assign stallM = dreq & ~dvalid;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning data/address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles in a busy state before abort.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ireq, input, 1, fetch-side read request, held until ivalid.
REQ-006 SHALL have port iaddr, input, WORD, fetch read address, stable while ireq is high.
REQ-007 SHALL have ports irdata output WORD and ivalid output 1, fetch read data and its one-cycle completion pulse.
REQ-008 SHALL have ports dreq input 1, dwe input 1 (1 = write), daddr input WORD and dwdata input WORD, the memory-stage request, held stable until dvalid.
REQ-009 SHALL have ports drdata output WORD and dvalid output 1, the memory-stage read data and its one-cycle completion pulse.
REQ-010 SHALL have ports mreq output 1, mwe output 1, maddr output WORD and mwdata output WORD, the shared single-port memory request.
REQ-011 SHALL have ports mready input 1 and mrdata input WORD; mready is a one-cycle completion strobe, and mrdata is valid in the same cycle.
REQ-012 SHALL have ports stallF output 1, stallM output 1 and err output 1, the fetch stall, memory-stage stall and sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, IBUSY and DBUSY, plus a 1-bit register lastD recording whether the last grant went to the data side.
REQ-014 SHALL, in IDLE, treat a request as eligible only if it is high and its own valid output is low in that cycle.
REQ-015 SHALL, in IDLE with only the data side eligible, go to DBUSY; with only the fetch side eligible, go to IBUSY.
REQ-016 SHALL, in IDLE with both sides eligible, grant the side not granted last: DBUSY if lastD=0, IBUSY if lastD=1.
REQ-017 SHALL, on each grant, update lastD and capture the address, write data and we into internal registers; in the fetch case we is captured as 0.
REQ-018 SHALL drive mreq=1 and maddr/mwe/mwdata from the captured registers in IBUSY and DBUSY, held unchanged until mready; mreq SHALL be 0 in IDLE.
REQ-019 SHALL, in IBUSY with mready=1, register irdata<=mrdata, pulse ivalid for the next cycle and return to IDLE.
REQ-020 SHALL, in DBUSY with mready=1, register drdata<=mrdata (read) or leave drdata unchanged (write), pulse dvalid for the next cycle and return to IDLE.
REQ-021 SHALL give a request-to-valid latency of 1 grant cycle + memory latency + 1 cycle; the minimum latency is 2 cycles when mready arrives in the first busy cycle.
REQ-022 SHALL drive stallF = ireq & ~ivalid and stallM = dreq & ~dvalid, combinationally.
REQ-023 SHALL ignore mready while in IDLE: no state change and no valid pulse.
REQ-024 SHALL count busy cycles with a counter that clears on entering a busy state.
REQ-025 SHALL, when the busy counter reaches TIMEOUT without mready, set err=1 (sticky until reset), return to IDLE and pulse the pending side's valid with its rdata forced to 0.
REQ-026 SHALL ensure ivalid and dvalid are never high in the same cycle, and that at most one grant is outstanding at any time.

Reset
REQ-027 SHALL, while reset=1, immediately force state=IDLE, lastD=0, counter=0, mreq=mwe=0, maddr=mwdata=0, irdata=drdata=0, ivalid=dvalid=0 and err=0.
REQ-028 SHALL, when reset asserts mid-transaction, discard the outstanding grant; a late mready after reset SHALL be ignored per REQ-023.

Verification
REQ-029 SHALL cover a single fetch: ireq=1, iaddr=0x100, mready one cycle after mreq with mrdata=0xDEADBEEF -> maddr=0x100, mwe=0, then ivalid=1 with irdata=0xDEADBEEF, stallF high until that cycle.
REQ-030 SHALL cover a simultaneous first request: ireq=dreq=1 right after reset -> data granted first (DBUSY); after dvalid, fetch granted (IBUSY).
REQ-031 SHALL cover back-to-back contention: ireq and dreq held continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-032 SHALL cover a data write: dreq=1, dwe=1, daddr=0x200, dwdata=0x55 -> mwe=1, maddr=0x200, mwdata=0x55 held until mready; dvalid pulses and drdata is unchanged.
REQ-033 SHALL cover a timeout with TIMEOUT=4: dreq=1 and mready never asserted -> after 4 busy cycles err=1, dvalid pulses with drdata=0, FSM returns to IDLE, and err stays 1.
REQ-034 SHALL cover reset mid-transaction: reset pulsed in IBUSY, then mready=1 -> all outputs are 0, no ivalid pulse, and state is IDLE.
